// File: rtl/enable_generator_counter.sv
`default_nettype none
// ============================================================================
// Module      : enable_generator_counter
// Description : Programmable-period timebase for the enable generator.
//               Counts 0..period-1, advancing once every prescale+1 clocks.
//               Start/stop is level-controlled through `enable`; a stop
//               request drains the current period before going idle.
//               Period and prescale are captured into shadow registers only
//               while idle or on a wrap step, so `count` is always 0 when the
//               downstream comparators pick up new thresholds.
// Ports       : clock        - system clock
//               reset        - synchronous, active-low reset
//               enable       - run request (level)
//               period       - counts per period, 0 = no operation
//               prescale     - count advances every prescale+1 clocks
//               count        - current count (registered)
//               period_tick  - one-clock pulse as count wraps to 0
//               running      - high while active, including the final tick
// Revision    : 1.0 - initial release
// ============================================================================
module enable_generator_counter #(
  parameter int COUNTER_WIDTH   = 32,
  parameter int PRESCALER_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [COUNTER_WIDTH-1:0]   period,
  input  logic [PRESCALER_WIDTH-1:0] prescale,
  output logic [COUNTER_WIDTH-1:0]   count,
  output logic                       period_tick,
  output logic                       running
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [COUNTER_WIDTH-1:0]   count_q, count_d;
  logic [COUNTER_WIDTH-1:0]   shadow_period_q, shadow_period_d;
  logic [PRESCALER_WIDTH-1:0] pc_q, pc_d;
  logic [PRESCALER_WIDTH-1:0] shadow_prescale_q, shadow_prescale_d;
  logic                       tick_q, tick_d;
  logic                       running_q, running_d;

  logic active;
  logic step;
  logic wrap;

  // --------------------------------------------------------------------------
  // Datapath: prescaler, count and shadow registers
  // --------------------------------------------------------------------------
  always_comb begin
    active            = (state_q != ST_IDLE);
    step              = active && (pc_q == shadow_prescale_q);
    // Shadow period is never 0 while active, so the subtraction cannot wrap.
    wrap              = step && (count_q == (shadow_period_q - COUNTER_WIDTH'(1)));

    count_d           = count_q;
    pc_d              = pc_q;
    tick_d            = 1'b0;
    shadow_period_d   = shadow_period_q;
    shadow_prescale_d = shadow_prescale_q;

    if (!active) begin
      count_d           = '0;
      pc_d              = '0;
      shadow_period_d   = period;
      shadow_prescale_d = prescale;
    end else begin
      if (step) begin
        pc_d = '0;
      end else begin
        pc_d = pc_q + PRESCALER_WIDTH'(1);
      end

      if (wrap) begin
        count_d           = '0;
        tick_d            = 1'b1;
        shadow_period_d   = period;
        shadow_prescale_d = prescale;
      end else if (step) begin
        count_d = count_q + COUNTER_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && (period != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        // A wrap that loads a zero period must stop, even when a DRAIN would
        // otherwise return to RUN: a zero period can never wrap again.
        if (wrap && (period == '0)) begin
          state_d = ST_IDLE;
        end else if (enable) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_DRAIN) && wrap) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: running stays high through the cycle of the final tick.
  // --------------------------------------------------------------------------
  always_comb begin
    running_d = (state_d != ST_IDLE) || tick_d;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      count_q           <= '0;
      pc_q              <= '0;
      tick_q            <= 1'b0;
      running_q         <= 1'b0;
      shadow_period_q   <= '0;
      shadow_prescale_q <= '0;
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      pc_q              <= pc_d;
      tick_q            <= tick_d;
      running_q         <= running_d;
      shadow_period_q   <= shadow_period_d;
      shadow_prescale_q <= shadow_prescale_d;
    end
  end

  assign count       = count_q;
  assign period_tick = tick_q;
  assign running     = running_q;

endmodule
`default_nettype wire
